serial_adder_seq: RTL

//  Bit-serial N-bit adder sequencer. It accepts two WIDTH-bit operands and a carry-in.

---
 rtl/serial_adder_pkg.sv | 20 ++
 rtl/fuladderwith_decod.sv | 24 ++
 rtl/serial_adder_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding,
// default operand width and the counter-width helper.
package serial_adder_pkg;

  // Default operand/result width.
  localparam int SA_WIDTH_DEF = 8;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fuladderwith_decod.sv
// 1-bit full adder built from a 3-to-8 decoder: sum and carry are ORs of
// the decoded minterms of {a, b, cin}.
module fuladderwith_decod (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  logic [7:0] dec;

  // One-hot decode of the input triple.
  always_comb begin
    // NOTE: default every bit first so no path leaves dec unassigned (no latch).
    dec = '0;
    dec[{a, b, cin}] = 1'b1;
  end

  // Odd number of ones -> sum; two or more ones -> carry.
  assign sum   = dec[1] | dec[2] | dec[4] | dec[7];
  assign carry = dec[3] | dec[5] | dec[6] | dec[7];

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial WIDTH-bit adder sequencer. Feeds one operand bit pair per clock
// plus the registered carry into a 1-bit full-adder cell, shifts the sum bit
// into an accumulator LSB first and publishes {cout, sum} with a done pulse.
module serial_adder_seq
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("serial_adder_seq: WIDTH must be in 1..64");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic             c_ff;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;

  fuladderwith_decod u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (c_ff),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at acc[0].
  if (WIDTH == 1) begin : g_acc_w1
    assign acc_next = fa_sum;
  end else begin : g_acc_wn
    assign acc_next = {fa_sum, acc[WIDTH-1:1]};
  end

  // Sequencer FSM and serial datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      c_ff  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= op_a;
            b_sh  <= op_b;
            c_ff  <= op_cin;
            acc   <= '0;
            cnt   <= '0;
            state <= ST_RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= ST_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end

        ST_RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          acc  <= acc_next;
          c_ff <= fa_carry;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            sum   <= acc_next;
            cout  <= fa_carry;
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= ST_DONE;
          end
        end

        default: begin
          state <= ST_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
